// File: rtl/fir_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_filter_pkg
//  Purpose  : Shared types and sizing helpers for the serial MAC FIR core.
//             Holds the controller state encoding, the coefficient bank count
//             and width functions used for the tap counter and accumulator.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package fir_filter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } fir_state_t;

  localparam int BANK_COUNT     = 4;
  localparam int BANK_SEL_WIDTH = 2;

  // Width of the tap counter / filter_size field.
  function automatic int fs_width(input int max_filter_size);
    return $clog2(max_filter_size);
  endfunction

  // Full product width plus enough headroom for MAX_FILTER_SIZE additions.
  function automatic int acc_width(input int input_width, input int max_filter_size);
    return 2 * input_width + $clog2(max_filter_size);
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module   : register_file
//  Purpose  : Coefficient store. Synchronous write, registered read with one
//             cycle of latency. A read of the address being written in the
//             same cycle returns the new data.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             w_en_in/addr/data - write port
//             r_en_in/r_addr_in - read request (data valid next cycle)
//             r_data_out      - registered read data
//  Revision : 1.0 - initial release
// ============================================================================
module register_file #(
  parameter int INPUT_WIDTH = 32,
  parameter int CELL_COUNT  = 64,
  parameter int ADDR_WIDTH  = $clog2(CELL_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_en_in,
  input  logic [ADDR_WIDTH-1:0]  w_addr_in,
  input  logic [INPUT_WIDTH-1:0] w_data_in,
  input  logic                   r_en_in,
  input  logic [ADDR_WIDTH-1:0]  r_addr_in,
  output logic [INPUT_WIDTH-1:0] r_data_out
);

  logic [INPUT_WIDTH-1:0] r_mem [CELL_COUNT];
  logic [INPUT_WIDTH-1:0] r_data;

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_en_in) begin
      r_mem[w_addr_in] <= w_data_in;
    end
  end

  // Write-first bypass: needed when a one-tap filter loads coef 0 while the
  // core is already prefetching coef 0 for the first RUN sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (r_en_in) begin
      if (w_en_in && (w_addr_in == r_addr_in)) begin
        r_data <= w_data_in;
      end else begin
        r_data <= r_mem[r_addr_in];
      end
    end
  end

  assign r_data_out = r_data;

endmodule
`default_nettype wire

// File: rtl/fir_filter_core.sv
`default_nettype none
// ============================================================================
//  Module   : fir_filter_core
//  Purpose  : Serial multiply-accumulate FIR filter. One tap per valid cycle,
//             one result per filter_size+1 taps, four coefficient banks
//             loaded through the sample port after an init_filter edge.
//  Config   : FIR_FILTER_SATURATE_EN - saturate the shifted result instead of
//             wrapping it to OUTPUT_WIDTH bits.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             flush_pipeline     - abort current window (coefs kept)
//             input_valid        - fir_input carries a coef/sample
//             init_filter        - coefficient load request (rising edge)
//             disable_freezing   - valid gap aborts a partial window
//             fir_input          - signed coefficient or sample
//             filter_size        - taps minus one
//             cur_dec_level      - coefficient bank select
//             downsample         - emit even-parity windows only
//             output_valid       - one-cycle result strobe
//             fir_output         - filter result (held between results)
//             error_flag         - sticky protocol error
//  Revision : 1.0 - initial release
// ============================================================================
module fir_filter_core
  import fir_filter_pkg::*;
#(
  parameter int MAX_FILTER_SIZE = 16,
  parameter int INPUT_WIDTH     = 32,
  parameter int OUTPUT_WIDTH    = 32,
  parameter int FRAC_BITS       = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush_pipeline,
  input  logic                               input_valid,
  input  logic                               init_filter,
  input  logic                               disable_freezing,
  input  logic [INPUT_WIDTH-1:0]             fir_input,
  input  logic [$clog2(MAX_FILTER_SIZE)-1:0] filter_size,
  input  logic [1:0]                         cur_dec_level,
  input  logic                               downsample,
  output logic                               output_valid,
  output logic [OUTPUT_WIDTH-1:0]            fir_output,
  output logic                               error_flag
);

  localparam int FSW   = fs_width(MAX_FILTER_SIZE);
  localparam int ACCW  = acc_width(INPUT_WIDTH, MAX_FILTER_SIZE);
  localparam int ADDRW = BANK_SEL_WIDTH + FSW;
  localparam logic [FSW-1:0] c_k_one = 1;

  fir_state_t r_state, w_state_next;

  logic                           r_init_d;
  logic [FSW-1:0]                 r_k, w_k_next;
  logic signed [ACCW-1:0]         r_acc, w_acc_sum;
  logic                           r_parity;
  logic                           r_out_valid;
  logic [OUTPUT_WIDTH-1:0]        r_out, w_result;
  logic                           r_err;
  logic [FSW-1:0]                 r_fs_d;
  logic [1:0]                     r_lvl_d;

  logic                           w_init_edge, w_accept, w_last;
  logic                           w_load_wr, w_run_tap, w_gap_abort, w_err_set;
  logic [INPUT_WIDTH-1:0]         w_coef_raw;
  logic signed [INPUT_WIDTH-1:0]  w_sample, w_coef;
  logic signed [2*INPUT_WIDTH-1:0] w_prod;

  // Control decode; priority is init edge > flush > input_valid.
  assign w_init_edge = init_filter & ~r_init_d;
  assign w_accept    = input_valid & ~w_init_edge & ~flush_pipeline;
  assign w_last      = (r_k == filter_size);
  assign w_load_wr   = (r_state == LOAD) & w_accept;
  assign w_run_tap   = (r_state == RUN) & w_accept;
  assign w_gap_abort = (r_state == RUN) & ~input_valid & disable_freezing & (r_k != '0);
  assign w_err_set   = (input_valid && (r_state == IDLE)) ||
                       (((filter_size != r_fs_d) || (cur_dec_level != r_lvl_d)) && (r_k != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_init_edge) begin
      w_state_next = LOAD;
    end else if (w_load_wr && w_last) begin
      w_state_next = RUN;
    end
  end

  always_comb begin
    w_k_next = r_k;
    if (w_init_edge || flush_pipeline || w_gap_abort) begin
      w_k_next = '0;
    end else if (w_load_wr || w_run_tap) begin
      w_k_next = w_last ? '0 : r_k + c_k_one;
    end
  end

  // The read address follows the tap index the core will hold after this
  // edge, so the coefficient for the next sample is already registered.
  register_file #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .CELL_COUNT  (BANK_COUNT * MAX_FILTER_SIZE),
    .ADDR_WIDTH  (ADDRW)
  ) u_coef_store (
    .clk        (clk),
    .rst        (rst),
    .w_en_in    (w_load_wr),
    .w_addr_in  ({cur_dec_level, r_k}),
    .w_data_in  (fir_input),
    .r_en_in    (1'b1),
    .r_addr_in  ({cur_dec_level, w_k_next}),
    .r_data_out (w_coef_raw)
  );

  assign w_sample  = fir_input;
  assign w_coef    = w_coef_raw;
  assign w_prod    = w_sample * w_coef;
  assign w_acc_sum = r_acc + $signed({{FSW{w_prod[2*INPUT_WIDTH-1]}}, w_prod});

`ifdef FIR_FILTER_SATURATE_EN
  localparam logic signed [ACCW-1:0] c_sat_max =
    $signed({{(ACCW-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}});
  localparam logic signed [ACCW-1:0] c_sat_min = ~c_sat_max;

  logic signed [ACCW-1:0] w_shifted;
  assign w_shifted = w_acc_sum >>> FRAC_BITS;

  always_comb begin
    w_result = w_shifted[OUTPUT_WIDTH-1:0];
    if (w_shifted > c_sat_max) begin
      w_result = c_sat_max[OUTPUT_WIDTH-1:0];
    end else if (w_shifted < c_sat_min) begin
      w_result = c_sat_min[OUTPUT_WIDTH-1:0];
    end
  end
`else
  assign w_result = OUTPUT_WIDTH'(w_acc_sum >>> FRAC_BITS);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_d    <= 1'b0;
      r_k         <= '0;
      r_acc       <= '0;
      r_parity    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_err       <= 1'b0;
      r_fs_d      <= '0;
      r_lvl_d     <= '0;
    end else begin
      r_init_d    <= init_filter;
      r_fs_d      <= filter_size;
      r_lvl_d     <= cur_dec_level;
      r_k         <= w_k_next;
      r_out_valid <= 1'b0;

      if (w_init_edge || flush_pipeline) begin
        r_acc    <= '0;
        r_parity <= 1'b0;
      end else if (w_gap_abort) begin
        r_acc <= '0;
      end else if (w_run_tap) begin
        if (w_last) begin
          r_acc    <= '0;
          r_parity <= ~r_parity;
          // Odd windows are still consumed but not presented when decimating.
          if (!downsample || !r_parity) begin
            r_out_valid <= 1'b1;
            r_out       <= w_result;
          end
        end else begin
          r_acc <= w_acc_sum;
        end
      end

      // An init edge clears the sticky flag unless it collides with a valid.
      if (w_init_edge) begin
        r_err <= input_valid;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign output_valid = r_out_valid;
  assign fir_output   = r_out;
  assign error_flag   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_filter_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_filter_core
//  Purpose  : Directed scoreboard bench for fir_filter_core (filter_size = 3,
//             Q16 coefficients). Expected results and their output cycles are
//             queued by the stimulus; a monitor compares on output_valid.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fir_filter_core;

  localparam int IW = 32;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_pipeline;
  logic          input_valid;
  logic          init_filter;
  logic          disable_freezing;
  logic [IW-1:0] fir_input;
  logic [3:0]    filter_size;
  logic [1:0]    cur_dec_level;
  logic          downsample;
  logic          output_valid;
  logic [OW-1:0] fir_output;
  logic          error_flag;

  always #5 clk = ~clk;

  fir_filter_core #(
    .MAX_FILTER_SIZE (16),
    .INPUT_WIDTH     (IW),
    .OUTPUT_WIDTH    (OW),
    .FRAC_BITS       (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_pipeline   (flush_pipeline),
    .input_valid      (input_valid),
    .init_filter      (init_filter),
    .disable_freezing (disable_freezing),
    .fir_input        (fir_input),
    .filter_size      (filter_size),
    .cur_dec_level    (cur_dec_level),
    .downsample       (downsample),
    .output_valid     (output_valid),
    .fir_output       (fir_output),
    .error_flag       (error_flag)
  );

  typedef struct packed {
    logic [OW-1:0] val;
    int            cyc;
  } exp_t;

  exp_t  sb_q[$];
  string sb_name[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output_valid pulse must match the oldest queued result,
  // both in value and in the cycle it was predicted for.
  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (!rst && output_valid) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got %h at cycle %0d, required no output", fir_output, cyc);
      end else begin
        e = sb_q.pop_front();
        n = sb_name.pop_front();
        if (fir_output !== e.val || cyc != e.cyc) begin
          bad++;
          $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                   n, fir_output, cyc, e.val, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input logic [OW-1:0] act, input logic [OW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", n, act, req);
    end
  endtask

  // Called just after the edge accepting the last tap: the pulse belongs
  // to the cycle that edge opens.
  task automatic expect_out(input logic [OW-1:0] v, input string n);
    exp_t e;
    e.val = v;
    e.cyc = cyc;
    sb_q.push_back(e);
    sb_name.push_back(n);
  endtask

  task automatic tap(input logic [IW-1:0] d);
    input_valid = 1'b1;
    fir_input   = d;
    tick();
    input_valid = 1'b0;
  endtask

  task automatic window(input int a, input int b, input int c, input int d,
                        input bit emit, input logic [OW-1:0] v, input string n);
    tap(a); tap(b); tap(c); tap(d);
    if (emit) expect_out(v, n);
  endtask

  task automatic init_pulse();
    init_filter = 1'b1;
    tick();
    init_filter = 1'b0;
  endtask

  task automatic load(input logic [1:0] lvl, input int c0, input int c1, input int c2, input int c3);
    cur_dec_level = lvl;
    init_pulse();
    tap(c0); tap(c1); tap(c2); tap(c3);
  endtask

  initial begin
    rst = 1'b1; flush_pipeline = 1'b0; input_valid = 1'b0; init_filter = 1'b0;
    disable_freezing = 1'b0; fir_input = '0; filter_size = 4'd3;
    cur_dec_level = 2'd0; downsample = 1'b0;
    repeat (3) tick();
    check("reset_output_valid", {31'd0, output_valid}, 32'd0);
    check("reset_fir_output", fir_output, 32'd0);
    check("reset_error_flag", {31'd0, error_flag}, 32'd0);
    rst = 1'b0;
    tick();

    // Data before any init is a protocol error; an init edge clears it.
    tap(32'd3);
    check("err_valid_in_idle", {31'd0, error_flag}, 32'd1);
    cur_dec_level = 2'd0;
    init_pulse();
    check("err_cleared_by_init", {31'd0, error_flag}, 32'd0);
    tap(32'h10000); tap(0); tap(0); tap(0);

    // Identity: only the newest sample of each window passes through.
    window(5, 1, 1, 1, 1'b1, 32'd5, "identity_5");
    window(7, 2, 2, 2, 1'b1, 32'd7, "identity_7");
    window(9, 3, 3, 3, 1'b1, 32'd9, "identity_9");

    // Moving sum, back-to-back windows.
    load(2'd0, 32'h10000, 32'h10000, 32'h10000, 32'h10000);
    window(1, 2, 3, 4, 1'b1, 32'd10, "sum_pos");
    window(-1, -2, -3, -4, 1'b1, -32'sd10, "sum_neg");

    // Decimation by two on an identity bank at level 1.
    load(2'd1, 32'h10000, 0, 0, 0);
    downsample = 1'b1;
    window(5, 0, 0, 0, 1'b1, 32'd5, "ds_5");
    window(7, 0, 0, 0, 1'b0, 32'd0, "ds_7");
    window(9, 0, 0, 0, 1'b1, 32'd9, "ds_9");
    window(11, 0, 0, 0, 1'b0, 32'd0, "ds_11");
    downsample = 1'b0;
    cur_dec_level = 2'd0;
    tick();

    // Freezing: the gap holds the partial window.
    tap(1); tap(2);
    repeat (3) tick();
    tap(3); tap(4);
    expect_out(32'd10, "freeze_hold");

    // Freezing disabled: the gap drops {1,2}; {3,4,5,6} forms a new window.
    disable_freezing = 1'b1;
    tap(1); tap(2);
    repeat (3) tick();
    tap(3); tap(4); tap(5); tap(6);
    expect_out(32'd18, "nofreeze_new_window");
    disable_freezing = 1'b0;

    // Flush discards the partial window.
    tap(1); tap(2);
    flush_pipeline = 1'b1;
    tick();
    flush_pipeline = 1'b0;
    window(1, 2, 3, 4, 1'b1, 32'd10, "after_flush");

    // Banks: level 0 sums, level 2 doubles.
    load(2'd2, 32'h20000, 32'h20000, 32'h20000, 32'h20000);
    cur_dec_level = 2'd0;
    tick();
    window(1, 1, 1, 1, 1'b1, 32'd4, "bank0");
    cur_dec_level = 2'd2;
    tick();
    window(1, 1, 1, 1, 1'b1, 32'd8, "bank2");
    check("err_clean_run", {31'd0, error_flag}, 32'd0);

    // Init edge colliding with a valid input.
    input_valid = 1'b1;
    fir_input   = 32'd1;
    init_filter = 1'b1;
    tick();
    init_filter = 1'b0;
    input_valid = 1'b0;
    check("err_init_with_valid", {31'd0, error_flag}, 32'd1);
    tick();

    // Full-scale products: 4*(2^31-1)^2 >>> 16 = 0xFFFFFFFC0000.
    load(2'd3, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    check("err_cleared_reload", {31'd0, error_flag}, 32'd0);
`ifdef FIR_FILTER_SATURATE_EN
    window(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, "saturate");
`else
    window(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'hFFFC0000, "wrap");
`endif

    repeat (5) tick();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL missing_outputs: got %0d results pending, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
